snake: RTL and testbench
========================

# snake

Snake game-state engine. Holds the body segment coordinates, current heading and length on a 32×32 grid. Advances the snake one cell per step tick while play is running, and flags food pickup, boundary collision and self collision. Sits between the game-control FSM, which supplies `game_state`, `pause`, `slow` and food position, and the VGA renderer and score logic, which consume the flattened segment arrays, `snake_length` and the event flags.

## Interface
- `STEP_CYCLES`, default 2_500_000: clk cycles per move in normal speed. Must be ≥2.
- `clk` input 1: system clock. All logic is on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `pause` input 1: 1 freezes step counter and movement.
- `slow` input 1: 1 makes the step period 2×`STEP_CYCLES`.
- `next_direction` input 2: requested heading. 00 up (y−1), 01 down (y+1), 10 left (x−1), 11 right (x+1).
- `game_state` input 2: 10 READY (load start snake), 00 RUN, 01 OVER, 11 treated as OVER.
- `food_x`, `food_y` input 5 each: food cell.
- `current_direction` output 2: heading used by the last or next move.
- `snake_x_1dim`, `snake_y_1dim` output 320 each: 64 segments × 5 bits. Segment i is at bits [5i+4:5i]. Segment 0 is the head. Slots ≥ `snake_length` read 0.
- `snake_length` output 6: valid segment count, 3..63.
- `hit_boundary` output 1: sticky; head tried to leave the grid.
- `hit_self` output 1: sticky; head entered its own body.
- `get_food` output 1: one-cycle pulse on food pickup.

## Operation
- Reset state, also loaded on every cycle `game_state`==READY:
  - length 3; head (10,10), seg1 (9,10), seg2 (8,10).
  - direction 11 (right).
  - flags 0; step counter 0.
- OVER: all state held. Outputs are frozen.
- Moves happen only when `game_state`==RUN, `pause`==0, no sticky hit flag set, and a step tick fires.
- On a move:
  - Heading: if `next_direction` is not the exact reverse of `current_direction`, it becomes the new heading; a reverse request is ignored.
  - New head = old head + heading delta.
  - Out-of-range check: x or y <0 or >31. If the new head is out of range, set `hit_boundary`; no position change.
  - Otherwise shift segments: seg[i] ← seg[i−1] for i in 1..63; seg0 ← new head.
  - If the new head equals (`food_x`,`food_y`): pulse `get_food`; length += 1, saturating at 63. The tail is kept, so the former last segment becomes valid.
  - Self-collision: if the new head equals any new-body segment 1..len_new−1, set `hit_self`. The move is still committed.
- Food and self collision on the same move: both reported.
- Sticky flags clear only on `rst` or READY.

## Timing
- Step counter counts clk cycles while RUN and not paused.
- Tick fires when the counter reaches limit−1, where limit = `STEP_CYCLES`, or 2×`STEP_CYCLES` when `slow`=1. The counter then returns to 0.
- Changing `slow` mid-count takes effect against the current count. If the count is already ≥ the new limit, tick on the next cycle.
- Pause holds the count without clearing it.
- All outputs are registered and update on the tick edge, with no extra latency.
- `get_food` is high exactly the one cycle following the tick edge.
- READY or `rst` has priority over a simultaneous tick.

## Configuration
- `SNAKE_WRAP_EN` defined: off-grid moves wrap modulo 32 (x −1→31, 32→0; same for y). `hit_boundary` is tied to 0.
- `SNAKE_WRAP_EN` undefined: boundary behaviour as in Operation.

## Test plan
- Reset: `rst`=1 one cycle, then `game_state`=READY → length 3; head (10,10); seg1 (9,10); seg2 (8,10); `current_direction`=11; flags 0.
- Ignored reverse request, with `STEP_CYCLES`=4: RUN, `next_direction`=10 → every 4 cycles head x increments (11,12,…); `current_direction` stays 11.
- Boundary: continue right → at head x=31 the next tick sets `hit_boundary`=1 and the snake stops. With `SNAKE_WRAP_EN`: head goes to x=0, no flag.
- Food: food (12,10) from start → 2nd tick gives `get_food` pulse, 1 cycle wide; length 4; seg3=(9,10).
- Self collision: length ≥5; issue direction sequence down, left, up → `hit_self`=1 on the move that re-enters the body; further ticks cause no movement.
- Pause and slow: `pause`=1 for 10 ticks' worth of cycles → no move; release → resumes with the count preserved. `slow`=1 → moves every 8 cycles.

Source files
------------

// File: rtl/snake_if.sv
// Snake engine control/status bundle.
//   master (game control + renderer side): drives pause, slow, next_direction,
//     game_state, food_x/food_y; reads heading, segment arrays, length, flags.
//   slave (snake engine): the reverse.
interface snake_if;
  logic         pause;
  logic         slow;
  logic [1:0]   next_direction;
  logic [1:0]   game_state;
  logic [4:0]   food_x;
  logic [4:0]   food_y;
  logic [1:0]   current_direction;
  logic [319:0] snake_x_1dim;
  logic [319:0] snake_y_1dim;
  logic [5:0]   snake_length;
  logic         hit_boundary;
  logic         hit_self;
  logic         get_food;

  modport master (
    output pause, slow, next_direction, game_state, food_x, food_y,
    input  current_direction, snake_x_1dim, snake_y_1dim, snake_length,
           hit_boundary, hit_self, get_food
  );
  modport slave (
    input  pause, slow, next_direction, game_state, food_x, food_y,
    output current_direction, snake_x_1dim, snake_y_1dim, snake_length,
           hit_boundary, hit_self, get_food
  );
endinterface

// File: rtl/snake.sv
// Snake game-state engine on a 32x32 grid.
// Holds up to 64 segment coordinates, heading and length; advances one cell
// per step tick while RUN and not paused; flags food pickup, boundary and
// self collision.
// Ports:
//   clk  - system clock (rising edge)
//   rst  - synchronous active-high reset
//   sif  - snake_if.slave: control inputs from game FSM, state/flags out.
// Build option: define SNAKE_WRAP_EN to wrap off-grid moves modulo 32
// (hit_boundary then stays 0).
module snake #(
  parameter int STEP_CYCLES = 2_500_000
) (
  input logic clk,
  input logic rst,
  snake_if.slave sif
);
  localparam int CW = $clog2(2*STEP_CYCLES) + 1;
  localparam logic [CW-1:0] LIM_N = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] LIM_S = CW'(2*STEP_CYCLES - 1);
  localparam logic [1:0] GS_RUN = 2'b00, GS_READY = 2'b10;
  localparam logic [1:0] D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11;
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [4:0]    seg_x [64];
  logic [4:0]    seg_y [64];
  logic [5:0]    len;
  logic [1:0]    dir;
  logic          hit_b, hit_s, food_p;
  logic [CW-1:0] cnt;

  logic       running, tick, do_move, oob, eat, self_hit;
  logic [1:0] dir_new;
  logic [4:0] nx, ny;
  logic [5:0] len_new;

  assign running = (sif.game_state == GS_RUN) && !sif.pause;
  // >= rather than == so a slow->fast switch past the new limit ticks at once
  assign tick    = running && (cnt >= (sif.slow ? LIM_S : LIM_N));
  assign do_move = tick && !hit_b && !hit_s;
  // up/down and left/right differ only in bit 0, so the reverse is dir^1
  assign dir_new = (sif.next_direction == (dir ^ 2'b01)) ? dir : sif.next_direction;

  // 5-bit arithmetic gives the wrapped cell for free; oob marks the edge case
  always_comb begin
    nx  = seg_x[0];
    ny  = seg_y[0];
    oob = 1'b0;
    case (dir_new)
      D_UP:    begin ny = seg_y[0] - 5'd1; oob = (seg_y[0] == 5'd0);  end
      D_DOWN:  begin ny = seg_y[0] + 5'd1; oob = (seg_y[0] == 5'd31); end
      D_LEFT:  begin nx = seg_x[0] - 5'd1; oob = (seg_x[0] == 5'd0);  end
      default: begin nx = seg_x[0] + 5'd1; oob = (seg_x[0] == 5'd31); end
    endcase
  end

  assign eat     = (nx == sif.food_x) && (ny == sif.food_y);
  assign len_new = (eat && len != 6'd63) ? len + 6'd1 : len;

  // New body seg[1..len_new-1] is old seg[0..len_new-2]; compare against the
  // pre-shift array so the vacated tail cell is only excluded when not eating.
  always_comb begin
    self_hit = 1'b0;
    for (int j = 0; j < 63; j++)
      if ((6'(j) < len_new - 6'd1) && nx == seg_x[j] && ny == seg_y[j])
        self_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    food_p <= 1'b0;
    if (rst || sif.game_state == GS_READY) begin
      for (int i = 0; i < 64; i++) begin
        seg_x[i] <= 5'd0;
        seg_y[i] <= 5'd0;
      end
      seg_x[0] <= 5'd10; seg_y[0] <= 5'd10;
      seg_x[1] <= 5'd9;  seg_y[1] <= 5'd10;
      seg_x[2] <= 5'd8;  seg_y[2] <= 5'd10;
      len   <= 6'd3;
      dir   <= D_RIGHT;
      hit_b <= 1'b0;
      hit_s <= 1'b0;
      cnt   <= '0;
    end else if (running) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (do_move) begin
        dir <= dir_new;
        if (oob && !WRAP) begin
          hit_b <= 1'b1;
        end else begin
          for (int i = 1; i < 64; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          len      <= len_new;
          food_p   <= eat;
          if (self_hit) hit_s <= 1'b1;
        end
      end
    end
  end

  // Flatten; slots beyond the valid length read 0 even though the registers
  // keep the old tail (needed when food extends the body).
  for (genvar g = 0; g < 64; g++) begin : g_flat
    assign sif.snake_x_1dim[5*g +: 5] = (6'(g) < len) ? seg_x[g] : 5'd0;
    assign sif.snake_y_1dim[5*g +: 5] = (6'(g) < len) ? seg_y[g] : 5'd0;
  end

  assign sif.current_direction = dir;
  assign sif.snake_length      = len;
  assign sif.hit_boundary      = hit_b;
  assign sif.hit_self          = hit_s;
  assign sif.get_food          = food_p;
endmodule

// File: tb/tb_snake.sv
module tb_snake;
  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rst;
  logic pause, slow;
  logic [1:0] nd, gs;
  logic [4:0] fx, fy;

  always #5 clk = ~clk;

  snake_if sif();
  assign sif.pause          = pause;
  assign sif.slow           = slow;
  assign sif.next_direction = nd;
  assign sif.game_state     = gs;
  assign sif.food_x         = fx;
  assign sif.food_y         = fy;

  snake #(.STEP_CYCLES(STEP)) dut (.clk(clk), .rst(rst), .sif(sif));

  int errors = 0;
  int checks = 0;

  // reference model: body as a queue, head at index 0
  int qx[$], qy[$];
  int m_dir, m_cnt;
  bit m_hb, m_hs, m_gf;

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    qx = '{10, 9, 8};
    qy = '{10, 10, 10};
    m_dir = 3; m_cnt = 0; m_hb = 0; m_hs = 0;
  endtask

  task automatic model_clk();
    int lim, hx, hy;
    bit tk, ate;
    m_gf = 0;
    if (rst || gs == 2'b10) begin model_reset(); return; end
    if (gs != 2'b00 || pause) return;
    lim = slow ? 2*STEP : STEP;
    m_cnt++;
    tk = (m_cnt >= lim);
    if (tk) m_cnt = 0;
    if (!tk || m_hb || m_hs) return;
    if (int'(nd) != opposite(m_dir)) m_dir = nd;
    hx = qx[0]; hy = qy[0];
    case (m_dir)
      0: hy--;
      1: hy++;
      2: hx--;
      default: hx++;
    endcase
    if (hx < 0 || hx > 31 || hy < 0 || hy > 31) begin
`ifdef SNAKE_WRAP_EN
      hx = (hx + 32) % 32;
      hy = (hy + 32) % 32;
`else
      m_hb = 1;
      return;
`endif
    end
    ate = (hx == int'(fx)) && (hy == int'(fy));
    qx.push_front(hx); qy.push_front(hy);
    if (!ate || qx.size() > 63) begin
      void'(qx.pop_back());
      void'(qy.pop_back());
    end
    m_gf = ate;
    for (int i = 1; i < qx.size(); i++)
      if (qx[i] == hx && qy[i] == hy) m_hs = 1;
  endtask

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    logic [319:0] ex, ey;
    @(posedge clk);
    model_clk();
    @(negedge clk);
    ex = '0; ey = '0;
    for (int i = 0; i < qx.size(); i++) begin
      ex[5*i +: 5] = 5'(qx[i]);
      ey[5*i +: 5] = 5'(qy[i]);
    end
    chk("snake_x",      sif.snake_x_1dim, ex);
    chk("snake_y",      sif.snake_y_1dim, ey);
    chk("length",       320'(sif.snake_length), 320'(qx.size()));
    chk("direction",    320'(sif.current_direction), 320'(m_dir));
    chk("hit_boundary", 320'(sif.hit_boundary), 320'(m_hb));
    chk("hit_self",     320'(sif.hit_self), 320'(m_hs));
    chk("get_food",     320'(sif.get_food), 320'(m_gf));
  endtask

  typedef struct {
    bit rst; bit [1:0] gs; bit pause, slow; bit [1:0] nd; bit [4:0] fx, fy; int n;
    bit [4:0] hx, hy; bit [5:0] len; bit [1:0] dir; bit hb, hs, gf;
  } row_t;
  row_t tbl[$];

  function automatic row_t mk(bit r, bit [1:0] g, bit p, bit s, bit [1:0] d, bit [4:0] a, bit [4:0] b,
                              int n, bit [4:0] hx, bit [4:0] hy, bit [5:0] l, bit [1:0] dr,
                              bit hb, bit hs, bit gf);
    row_t t;
    t = '{r, g, p, s, d, a, b, n, hx, hy, l, dr, hb, hs, gf};
    return t;
  endfunction

  initial begin
    rst = 1; gs = 2'b10; pause = 0; slow = 0; nd = 2'b11; fx = 0; fy = 0;
    // rst gs pause slow nd fx fy cycles | head_x head_y len dir hb hs gf
    tbl.push_back(mk(1, 2'b10, 0, 0, 2'b11, 0, 0, 1,   10, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 2'b11, 0, 0, 1,   10, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b10, 0, 0, 4,   11, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b10, 0, 0, 4,   12, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 2'b10, 0, 0, 40,  12, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b10, 0, 0, 4,   13, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 72,  31, 10, 3, 3, 0, 0, 0));
`ifdef SNAKE_WRAP_EN
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 4,    0, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 8,    2, 10, 3, 3, 0, 0, 0));
`else
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 4,   31, 10, 3, 3, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 8,   31, 10, 3, 3, 1, 0, 0));
`endif
    tbl.push_back(mk(0, 2'b10, 0, 0, 2'b11, 0, 0, 1,   10, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 12, 10, 8, 12, 10, 4, 3, 0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 12, 10, 1, 12, 10, 4, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 13, 10, 3, 13, 10, 5, 3, 0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b01, 0, 0, 4,   13, 11, 5, 1, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b10, 0, 0, 4,   12, 11, 5, 2, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 4,   12, 10, 5, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 8,   12, 10, 5, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 2'b11, 0, 0, 1,   10, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 2'b11, 0, 0, 8,   11, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 2'b11, 0, 0, 8,   12, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 2'b11, 0, 0, 5,   12, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 1,   13, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 2,   13, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 2'b11, 0, 0, 20,  13, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 1,   13, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 1,   14, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0, 0, 2'b00, 0, 0, 20,  14, 10, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 2'b00, 0, 0, 8,   14, 10, 3, 3, 0, 0, 0));

    foreach (tbl[k]) begin
      rst = tbl[k].rst; gs = tbl[k].gs; pause = tbl[k].pause; slow = tbl[k].slow;
      nd = tbl[k].nd; fx = tbl[k].fx; fy = tbl[k].fy;
      repeat (tbl[k].n) cyc();
      chk($sformatf("row%0d head_x", k), 320'(sif.snake_x_1dim[4:0]), 320'(tbl[k].hx));
      chk($sformatf("row%0d head_y", k), 320'(sif.snake_y_1dim[4:0]), 320'(tbl[k].hy));
      chk($sformatf("row%0d len", k),    320'(sif.snake_length), 320'(tbl[k].len));
      chk($sformatf("row%0d dir", k),    320'(sif.current_direction), 320'(tbl[k].dir));
      chk($sformatf("row%0d hb", k),     320'(sif.hit_boundary), 320'(tbl[k].hb));
      chk($sformatf("row%0d hs", k),     320'(sif.hit_self), 320'(tbl[k].hs));
      chk($sformatf("row%0d gf", k),     320'(sif.get_food), 320'(tbl[k].gf));
    end

    // randomized play against the queue model; food kept near the head
    rst = 0; gs = 2'b10; pause = 0; slow = 0;
    cyc();
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 199));
      rst   = (r == 0);
      gs    = (r < 4) ? 2'b10 : (r < 7) ? 2'($urandom_range(0, 1) * 2 + 1) : 2'b00;
      pause = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) slow = ~slow;
      if ($urandom_range(0, 5) == 0) nd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        fx = 5'((qx[0] + int'($urandom_range(0, 2)) - 1 + 32) % 32);
        fy = 5'((qy[0] + int'($urandom_range(0, 2)) - 1 + 32) % 32);
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
